// File: rtl/axi4_rd_mem_slave.sv
// AXI4 read responder (AR/R) over an internal word memory with a backdoor write port.
// Latency: first R beat 1 cycle after the AR handshake, then one beat per cycle; R is held stable while r_ready is low.
module axi4_rd_mem_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         aclk,
    input  logic                         arst_n,
    input  logic [ID_WIDTH-1:0]          ar_id,
    input  logic [ADDR_WIDTH-1:0]        ar_addr,
    input  logic [7:0]                   ar_len,
    input  logic [2:0]                   ar_size,
    input  logic [1:0]                   ar_burst,
    input  logic                         ar_lock,
    input  logic [3:0]                   ar_cache,
    input  logic [2:0]                   ar_prot,
    input  logic [3:0]                   ar_qos,
    input  logic [3:0]                   ar_region,
    input  logic [USER_WIDTH-1:0]        ar_user,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    output logic [ID_WIDTH-1:0]          r_id,
    output logic [DATA_WIDTH-1:0]        r_data,
    output logic [1:0]                   r_resp,
    output logic                         r_last,
    output logic [USER_WIDTH-1:0]        r_user,
    output logic                         r_valid,
    input  logic                         r_ready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);

    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic {IDLE, BEAT} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    ar_ready_q;
    logic                    r_valid_q;
    logic                    r_last_q;
    logic [1:0]              r_resp_q;
    logic [ID_WIDTH-1:0]     r_id_q;
    logic [DATA_WIDTH-1:0]   r_data_q;
    logic [USER_WIDTH-1:0]   r_user_q;

    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic                    ar_hs;
    logic                    r_hs;
    logic                    ld_en;
    logic                    ar_err;
    logic                    ld_err;
    logic [ADDR_WIDTH-1:0]   ar_bytes;
    logic [ADDR_WIDTH-1:0]   ar_start;
    logic [ADDR_WIDTH-1:0]   cur_bytes;
    logic [ADDR_WIDTH-1:0]   wrap_mask;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [ADDR_WIDTH-1:0]   ld_word;
    logic [7:0]              cnt_d;
    logic                    r_last_d;
    logic [DATA_WIDTH-1:0]   r_data_d;
    logic [1:0]              r_resp_d;

    logic                    unused_ok;
    assign unused_ok = ^{ar_lock, ar_cache, ar_prot, ar_qos, ar_region};

    always_comb begin
        ar_hs     = ar_valid & ar_ready_q;
        r_hs      = r_valid_q & r_ready;
        ld_en     = ar_hs | (r_hs & ~r_last_q);

        ar_bytes  = ADDR_WIDTH'(1) << ar_size;
        ar_start  = ar_addr & ~(ar_bytes - ADDR_WIDTH'(1));
        ar_err    = (ar_size > 3'(LSB)) || (ar_burst == BURST_RSVD) ||
                    ((ar_burst == BURST_WRAP) &&
                     !((ar_len == 8'd1) || (ar_len == 8'd3) || (ar_len == 8'd7) || (ar_len == 8'd15)));

        // WRAP window is the (len+1)*B container the current address sits in
        cur_bytes = ADDR_WIDTH'(1) << size_q;
        wrap_mask = cur_bytes * (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) - ADDR_WIDTH'(1);
        case (burst_q)
            BURST_FIXED: nxt_addr = addr_q;
            BURST_WRAP:  nxt_addr = (addr_q & ~wrap_mask) | ((addr_q + cur_bytes) & wrap_mask);
            default:     nxt_addr = addr_q + cur_bytes;
        endcase

        addr_d    = ar_hs ? ar_start : nxt_addr;
        ld_err    = ar_hs ? ar_err : err_q;
        ld_word   = addr_d >> LSB;
        cnt_d     = ar_hs ? 8'd0 : cnt_q + 8'd1;
        r_last_d  = ar_hs ? (ar_len == 8'd0) : (cnt_d == len_q);

        r_data_d  = '0;
        r_resp_d  = RESP_SLVERR;
        if (!ld_err && (ld_word < ADDR_WIDTH'(MEM_DEPTH))) begin
            r_data_d = mem_q[ld_word[IDX_W-1:0]];
            r_resp_d = RESP_OKAY;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= '0;
            r_id_q     <= '0;
            r_data_q   <= '0;
            r_user_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            if (state_q == IDLE) begin
                ar_ready_q <= 1'b1;
                if (ar_hs) begin
                    state_q    <= BEAT;
                    ar_ready_q <= 1'b0;
                    r_valid_q  <= 1'b1;
                    len_q      <= ar_len;
                    size_q     <= ar_size;
                    burst_q    <= ar_burst;
                    err_q      <= ar_err;
                    r_id_q     <= ar_id;
                    r_user_q   <= ar_user;
                end
            end else if (r_hs && r_last_q) begin
                state_q    <= IDLE;
                r_valid_q  <= 1'b0;
                ar_ready_q <= 1'b1;
            end

            if (ld_en) begin
                addr_q   <= addr_d;
                cnt_q    <= cnt_d;
                r_data_q <= r_data_d;
                r_resp_q <= r_resp_d;
                r_last_q <= r_last_d;
            end
        end
    end

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_last   = r_last_q;
    assign r_resp   = r_resp_q;
    assign r_id     = r_id_q;
    assign r_data   = r_data_q;
    assign r_user   = r_user_q;

endmodule

// File: tb/tb_axi4_rd_mem_slave.sv
// Directed bench for axi4_rd_mem_slave: burst table plus backpressure, backdoor-collision and mid-burst reset sequences.
module tb_axi4_rd_mem_slave;

    logic        aclk = 1'b0;
    logic        arst_n;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_lock;
    logic [3:0]  ar_cache;
    logic [2:0]  ar_prot;
    logic [3:0]  ar_qos;
    logic [3:0]  ar_region;
    logic [0:0]  ar_user;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [0:0]  r_user;
    logic        r_valid;
    logic        r_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [63:0] mem_wdata;

    axi4_rd_mem_slave dut (
        .aclk(aclk), .arst_n(arst_n),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_qos(ar_qos), .ar_region(ar_region), .ar_user(ar_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_user(r_user), .r_valid(r_valid), .r_ready(r_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_mem [256];

    typedef struct {
        string           nm;
        logic [3:0]      id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic            user;
        logic [3:0][8:0] w;
        logic [3:0]      err;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [63:0] pat(input int w);
        return {16'hC0DE, 16'(w), 16'hBEEF, 16'(w) ^ 16'h5A5A};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic user);
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size;
        ar_burst = burst; ar_user = user; ar_valid = 1'b1;
    endtask

    // Issues one AR with r_ready held high and checks every beat against the model.
    task automatic run_burst(input string nm, input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input logic user, input logic [3:0][8:0] w, input logic [3:0] err);
        int n;
        logic [63:0] exp;
        drive_ar(id, addr, len, size, burst, user);
        r_ready = 1'b1;
        n = 0;
        while (!ar_ready && n < 20) begin
            tick();
            n++;
        end
        if (!ar_ready) begin
            chk({nm, " ar_ready_timeout"}, 64'(ar_ready), 64'd1);
            ar_valid = 1'b0;
            return;
        end
        tick();
        ar_valid = 1'b0;
        chk({nm, " latency"}, 64'(r_valid), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            exp = 64'd0;
            if (!err[b]) exp = exp_mem[w[b][7:0]];
            chk($sformatf("%s b%0d valid", nm, b), 64'(r_valid), 64'd1);
            chk($sformatf("%s b%0d data", nm, b), r_data, exp);
            chk($sformatf("%s b%0d resp", nm, b), 64'(r_resp), err[b] ? 64'd2 : 64'd0);
            chk($sformatf("%s b%0d last", nm, b), 64'(r_last), (b == int'(len)) ? 64'd1 : 64'd0);
            chk($sformatf("%s b%0d id", nm, b), 64'(r_id), 64'(id));
            chk($sformatf("%s b%0d user", nm, b), 64'(r_user), 64'(user));
            tick();
        end
        chk({nm, " done ar_ready"}, 64'(ar_ready), 64'd1);
        chk({nm, " done r_valid"}, 64'(r_valid), 64'd0);
    endtask

    initial begin
        int k;
        logic [63:0] old0, old1;
        logic [63:0] new0, new1;
        bit rr_pat [4];

        arst_n = 1'b0; ar_valid = 1'b0; r_ready = 1'b0; mem_we = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_user = '0;
        ar_lock = 1'b0; ar_cache = '0; ar_prot = '0; ar_qos = '0; ar_region = '0;
        mem_waddr = '0; mem_wdata = '0;

        vecs[0] = '{"single_incr",    4'd3,  32'h28,  8'd0, 3'd3, 2'd1, 1'b1, {9'd0, 9'd0, 9'd0, 9'd5},   4'b0000};
        vecs[1] = '{"wrap4",          4'd1,  32'h30,  8'd3, 3'd3, 2'd2, 1'b0, {9'd5, 9'd4, 9'd7, 9'd6},   4'b0000};
        vecs[2] = '{"wrap_len2",      4'd2,  32'h30,  8'd2, 3'd3, 2'd2, 1'b1, {9'd0, 9'd0, 9'd0, 9'd0},   4'b0111};
        vecs[3] = '{"fixed_narrow",   4'd4,  32'h44,  8'd2, 3'd2, 2'd0, 1'b0, {9'd0, 9'd8, 9'd8, 9'd8},   4'b0000};
        vecs[4] = '{"size_too_big",   4'd5,  32'h0,   8'd1, 3'd4, 2'd1, 1'b0, {9'd0, 9'd0, 9'd0, 9'd0},   4'b0011};
        vecs[5] = '{"out_of_range",   4'd6,  32'h7F8, 8'd1, 3'd3, 2'd1, 1'b1, {9'd0, 9'd0, 9'd0, 9'd255}, 4'b0010};
        vecs[6] = '{"reserved_burst", 4'd7,  32'h8,   8'd0, 3'd3, 2'd3, 1'b0, {9'd0, 9'd0, 9'd0, 9'd0},   4'b0001};
        vecs[7] = '{"incr_unaligned", 4'd8,  32'h2D,  8'd1, 3'd3, 2'd1, 1'b0, {9'd0, 9'd0, 9'd6, 9'd5},   4'b0000};
        vecs[8] = '{"wrap2",          4'd9,  32'h38,  8'd1, 3'd3, 2'd2, 1'b1, {9'd0, 9'd0, 9'd6, 9'd7},   4'b0000};
        vecs[9] = '{"incr_narrow",    4'd10, 32'h0,   8'd3, 3'd2, 2'd1, 1'b0, {9'd1, 9'd1, 9'd0, 9'd0},   4'b0000};

        // Preload through the backdoor while reset is held
        for (int w = 0; w < 256; w++) begin
            exp_mem[w] = (w == 5) ? 64'hA5A5 : pat(w);
            mem_we = 1'b1; mem_waddr = 8'(w); mem_wdata = exp_mem[w];
            tick();
        end
        mem_we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst%0d ar_ready", c), 64'(ar_ready), 64'd0);
            chk($sformatf("rst%0d r_valid", c), 64'(r_valid), 64'd0);
            chk($sformatf("rst%0d r_last", c), 64'(r_last), 64'd0);
            chk($sformatf("rst%0d r_resp", c), 64'(r_resp), 64'd0);
            chk($sformatf("rst%0d r_id", c), 64'(r_id), 64'd0);
            chk($sformatf("rst%0d r_data", c), r_data, 64'd0);
            chk($sformatf("rst%0d r_user", c), 64'(r_user), 64'd0);
        end
        arst_n = 1'b1;
        tick();
        chk("post_rst ar_ready", 64'(ar_ready), 64'd1);
        chk("post_rst r_valid", 64'(r_valid), 64'd0);

        foreach (vecs[i])
            run_burst(vecs[i].nm, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                      vecs[i].burst, vecs[i].user, vecs[i].w, vecs[i].err);

        // Backpressure: r_ready pattern 1,0,0,1 repeating
        rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        r_ready = 1'b0;
        drive_ar(4'hA, 32'h0, 8'd3, 3'd3, 2'd1, 1'b0);
        tick();
        ar_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            r_ready = rr_pat[c % 4];
            chk($sformatf("bp c%0d valid", c), 64'(r_valid), 64'd1);
            chk($sformatf("bp c%0d data", c), r_data, exp_mem[k]);
            chk($sformatf("bp c%0d last", c), 64'(r_last), (k == 3) ? 64'd1 : 64'd0);
            chk($sformatf("bp c%0d id", c), 64'(r_id), 64'hA);
            if (r_valid && r_ready) k++;
            tick();
        end
        r_ready = 1'b0;
        chk("bp beats", 64'(k), 64'd4);
        chk("bp done r_valid", 64'(r_valid), 64'd0);
        chk("bp done ar_ready", 64'(ar_ready), 64'd1);

        // Backdoor writes racing a held beat and a beat load
        old0 = exp_mem[0]; old1 = exp_mem[1];
        new0 = 64'h1111_2222_3333_4444; new1 = 64'h5555_6666_7777_8888;
        drive_ar(4'h1, 32'h0, 8'd1, 3'd3, 2'd1, 1'b0);
        tick();
        ar_valid = 1'b0;
        chk("bd beat0", r_data, old0);
        mem_we = 1'b1; mem_waddr = 8'd0; mem_wdata = new0;
        tick();
        chk("bd held beat0", r_data, old0);
        chk("bd held valid", 64'(r_valid), 64'd1);
        exp_mem[0] = new0;
        mem_waddr = 8'd1; mem_wdata = new1; r_ready = 1'b1;
        tick();
        mem_we = 1'b0;
        chk("bd collide beat1", r_data, old1);
        chk("bd collide last", 64'(r_last), 64'd1);
        tick();
        chk("bd done r_valid", 64'(r_valid), 64'd0);
        exp_mem[1] = new1;
        run_burst("bd reread", 4'h2, 32'h0, 8'd1, 3'd3, 2'd1, 1'b1, {9'd0, 9'd0, 9'd1, 9'd0}, 4'b0000);

        // Reset in the middle of a burst
        drive_ar(4'h6, 32'h10, 8'd3, 3'd3, 2'd1, 1'b0);
        r_ready = 1'b1;
        tick();
        ar_valid = 1'b0;
        chk("mid beat0", r_data, exp_mem[2]);
        tick();
        chk("mid beat1", r_data, exp_mem[3]);
        arst_n = 1'b0;
        tick();
        chk("mid rst r_valid", 64'(r_valid), 64'd0);
        chk("mid rst ar_ready", 64'(ar_ready), 64'd0);
        arst_n = 1'b1;
        tick();
        chk("mid rel ar_ready", 64'(ar_ready), 64'd1);
        chk("mid rel r_valid", 64'(r_valid), 64'd0);
        run_burst("mid clean", vecs[1].id, vecs[1].addr, vecs[1].len, vecs[1].size,
                  vecs[1].burst, vecs[1].user, vecs[1].w, vecs[1].err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
